// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES key-schedule definitions: key-length encodings,
//            Nk/Nr lookups, FSM state type, S-box and GF(2^8) xtime.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Key-length encodings as presented on key_len_i
    localparam logic [1:0] KEYLEN_128 = 2'd0;
    localparam logic [1:0] KEYLEN_192 = 2'd1;
    localparam logic [1:0] KEYLEN_256 = 2'd2;

    // Sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte substitution; ~x selects the byte counted from the MSB end
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX_TABLE[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Key length in 32-bit words
    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEYLEN_192: return 4'd6;
            KEYLEN_256: return 4'd8;
            default:    return 4'd4;
        endcase
    endfunction

    // Number of rounds
    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEYLEN_192: return 4'd12;
            KEYLEN_256: return 4'd14;
            default:    return 4'd10;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_word
// Purpose  : Purely combinational SubWord - four parallel S-box lookups.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    import aes_pkg::*;

    // One S-box per byte lane
    for (genvar k = 0; k < 4; k++) begin : g_sbox
        assign o_word[8*k +: 8] = sbox(i_word[8*k +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_expansion_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expansion_seq
// Purpose  : Iterative AES-128/192/256 key schedule. One 32-bit schedule word
//            per cycle through a single shared SubWord unit; words are packed
//            into 128-bit round keys and streamed on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expansion_seq #(
    parameter bit ENABLE_192 = 1'b1,
    parameter bit ENABLE_256 = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx_o,
    output logic         rk_last_o,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    import aes_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;

    logic [1:0]     r_mode;
    logic [255:0]   r_key;
    logic [5:0]     r_cnt;      // schedule word index i
    logic [2:0]     r_kmod;     // i mod Nk
    logic [7:0]     r_rcon;
    logic [31:0]    r_win [0:7];// newest word at position 0
    logic [31:0]    r_lane0;
    logic [31:0]    r_lane1;
    logic [31:0]    r_lane2;

    logic [127:0]   r_rk;
    logic [3:0]     r_rk_idx;
    logic           r_rk_last;
    logic           r_rk_valid;
    logic           r_done;
    logic           r_err;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic           w_mode_legal;
    logic           w_load;
    logic           w_err;
    logic           w_finish;
    logic           w_accept;
    logic           w_stall;
    logic           w_gen_en;
    logic [3:0]     w_nk;
    logic [3:0]     w_nr;
    logic [2:0]     w_nk_m1;
    logic [5:0]     w_cnt_end;
    logic           w_in_key;
    logic           w_rot_slot;
    logic           w_sub_slot;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_temp;
    logic [31:0]    w_key_word;
    logic [31:0]    w_word;
    logic [2:0]     w_kmod_nxt;

    assign w_nk       = nk_of(r_mode);
    assign w_nr       = nr_of(r_mode);
    assign w_nk_m1    = w_nk[2:0] - 3'd1;          // 4->3, 6->5, 8->7
    assign w_cnt_end  = {w_nr + 4'd1, 2'b00};      // total words 4*(Nr+1)
    assign w_in_key   = (r_cnt < {2'b00, w_nk});
    assign w_accept   = r_rk_valid & rk_ready_i;

    // Only the word that completes a round key must wait for the consumer
    assign w_stall    = (r_cnt[1:0] == 2'd3) & r_rk_valid & ~rk_ready_i;
    assign w_gen_en   = (r_state == ST_GEN) & (r_cnt != w_cnt_end) & ~w_stall;

    assign w_prev     = r_win[0];
    assign w_back     = r_win[w_nk_m1];
    assign w_rot_slot = (r_kmod == 3'd0);
    assign w_sub_slot = (w_nk == 4'd8) & (r_kmod == 3'd4);

    // RotWord is applied ahead of the shared SubWord only on the Nk boundary
    assign w_sub_in   = w_rot_slot ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Select the transform applied to w[i-1]
    always_comb begin
        w_temp = w_prev;
        if (w_rot_slot) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_sub_slot) begin
            w_temp = w_sub_out;
        end
    end

    // Key word i sits at bits [255-32i -: 32]; ~i[2:0] is 7-i
    assign w_key_word = r_key[{~r_cnt[2:0], 5'b00000} +: 32];
    assign w_word     = w_in_key ? w_key_word : (w_back ^ w_temp);
    assign w_kmod_nxt = (r_kmod == w_nk_m1) ? 3'd0 : r_kmod + 3'd1;

    // Decode whether the requested key length is built into this instance
    always_comb begin
        case (key_len_i)
            KEYLEN_128: w_mode_legal = 1'b1;
            KEYLEN_192: w_mode_legal = ENABLE_192;
            KEYLEN_256: w_mode_legal = ENABLE_256;
            default:    w_mode_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_mode_legal) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_GEN;
                    end else begin
                        w_err       = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                if (w_accept && r_rk_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Schedule datapath registers
    // ------------------------------------------------------------------

    // Latch key on start, then advance one schedule word per enabled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode  <= KEYLEN_128;
            r_key   <= '0;
            r_cnt   <= '0;
            r_kmod  <= '0;
            r_rcon  <= 8'h01;
            r_lane0 <= '0;
            r_lane1 <= '0;
            r_lane2 <= '0;
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_load) begin
            r_mode  <= key_len_i;
            r_key   <= key_i;
            r_cnt   <= '0;
            r_kmod  <= '0;
            r_rcon  <= 8'h01;
        end else if (w_gen_en) begin
            r_cnt  <= r_cnt + 6'd1;
            r_kmod <= w_kmod_nxt;
            if (!w_in_key && w_rot_slot) begin
                r_rcon <= xtime(r_rcon);
            end
            r_win[0] <= w_word;
            for (int k = 1; k < 8; k++) begin
                r_win[k] <= r_win[k-1];
            end
            case (r_cnt[1:0])
                2'd0:    r_lane0 <= w_word;
                2'd1:    r_lane1 <= w_word;
                2'd2:    r_lane2 <= w_word;
                default: ;
            endcase
        end
    end

    // Round-key output register and valid/ready handshake; status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_last  <= 1'b0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_err;
            if (w_gen_en && (r_cnt[1:0] == 2'd3)) begin
                // A load on the accept edge keeps valid asserted
                r_rk       <= {r_lane0, r_lane1, r_lane2, w_word};
                r_rk_idx   <= r_cnt[5:2];
                r_rk_last  <= (r_cnt[5:2] == w_nr);
                r_rk_valid <= 1'b1;
            end else if (w_accept) begin
                r_rk_valid <= 1'b0;
                r_rk_last  <= 1'b0;
            end
        end
    end

    assign rk_o       = r_rk;
    assign rk_idx_o   = r_rk_idx;
    assign rk_last_o  = r_rk_last;
    assign rk_valid_o = r_rk_valid;
    assign busy_o     = (r_state == ST_GEN);
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expansion_seq
// Purpose  : Scoreboard bench for aes_key_expansion_seq using FIPS-197
//            key-schedule vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expansion_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic         d2_start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         rdy;
    logic         d2_rdy;

    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last, rk_valid, busy, done, err;
    logic [127:0] d2_rk;
    logic [3:0]   d2_rk_idx;
    logic         d2_rk_last, d2_rk_valid, d2_busy, d2_done, d2_err;

    aes_key_expansion_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .key_len_i(key_len), .key_i(key),
        .rk_o(rk), .rk_idx_o(rk_idx), .rk_last_o(rk_last), .rk_valid_o(rk_valid),
        .rk_ready_i(rdy), .busy_o(busy), .done_o(done), .err_o(err)
    );

    aes_key_expansion_seq #(.ENABLE_192(1'b0), .ENABLE_256(1'b1)) dut_n192 (
        .clk_i(clk), .rst_i(rst), .start_i(d2_start), .key_len_i(key_len), .key_i(key),
        .rk_o(d2_rk), .rk_idx_o(d2_rk_idx), .rk_last_o(d2_rk_last), .rk_valid_o(d2_rk_valid),
        .rk_ready_i(d2_rdy), .busy_o(d2_busy), .done_o(d2_done), .err_o(d2_err)
    );

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
        bit           chk_rk;
        int           edge_n;   // expected edges after start, -1 = unchecked
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   e0_cyc = 0;
    int   stall_idx = -1;
    bit   stall_used = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Hand-derived FIPS-197 round keys; 0 where the vector is not tabulated
    function automatic logic [127:0] exp_rk(input int len, input int j);
        logic [127:0] v;
        v = '0;
        if (len == 0) begin
            case (j)
                0:  v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
                1:  v = 128'ha0fafe1788542cb123a339392a6c7605;
                2:  v = 128'hf2c295f27a96b9435935807a7359f67f;
                3:  v = 128'h3d80477d4716fe3e1e237e446d7a883b;
                4:  v = 128'hef44a541a8525b7fb671253bdb0bad00;
                5:  v = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
                6:  v = 128'h6d88a37a110b3efddbf98641ca0093fd;
                7:  v = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
                8:  v = 128'head27321b58dbad2312bf5607f8d292f;
                9:  v = 128'hac7766f319fadc2128d12941575c006e;
                10: v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
                default: v = '0;
            endcase
        end else if (len == 1) begin
            case (j)
                0:  v = 128'h000102030405060708090a0b0c0d0e0f;
                1:  v = 128'h10111213141516175846f2f95c43f4fe;
                2:  v = 128'h544afef55847f0fa4856e2e95c43f4fe;
                12: v = 128'ha4970a331a78dc09c418c271e3a41d5d;
                default: v = '0;
            endcase
        end else begin
            case (j)
                0:  v = 128'h000102030405060708090a0b0c0d0e0f;
                1:  v = 128'h101112131415161718191a1b1c1d1e1f;
                2:  v = 128'ha573c29fa176c498a97fce93a572c09c;
                3:  v = 128'h1651a8cd0244beda1a5da4c10640bade;
                14: v = 128'h24fc79ccbf0979e9371ac23c6d68de36;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Queue the expected round-key stream for one schedule
    task automatic push_sched(input int len, input bit timed);
        int   nr;
        exp_t e;
        nr = (len == 0) ? 10 : (len == 1) ? 12 : 14;
        for (int j = 0; j <= nr; j++) begin
            e.rk     = exp_rk(len, j);
            e.idx    = 4'(j);
            e.last   = (j == nr);
            e.chk_rk = (e.rk != '0);
            e.edge_n = timed ? 4*j + 4 : -1;
            sb_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; the next rising edge is E0
    task automatic start_run(input logic [1:0] len, input logic [255:0] k);
        key_len = len;
        key     = k;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e0_cyc  = cyc;
    endtask

    // Returns just after the edge that raises done_o
    task automatic wait_done(input int bound);
        bit seen;
        seen = 0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check(seen, "done_seen", 128'(seen), 128'd1);
    endtask

    // Illegal start: sel=0 mode 3 on the full DUT, sel=1 mode 1 on the 192-less DUT
    task automatic err_test(input bit sel);
        key_len = sel ? 2'd1 : 2'd3;
        key     = K256;
        if (sel) d2_start = 1'b1;
        else     start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        d2_start = 1'b0;
        @(negedge clk);
        check((sel ? d2_err : err) == 1'b1, sel ? "err_pulse_n192" : "err_pulse_m3",
              128'(sel ? d2_err : err), 128'd1);
        check((sel ? d2_busy : busy) == 1'b0, "err_busy_low", 128'(sel ? d2_busy : busy), 128'd0);
        @(negedge clk);
        check((sel ? d2_err : err) == 1'b0, "err_one_cycle", 128'(sel ? d2_err : err), 128'd0);
        check((sel ? d2_rk_valid : rk_valid) == 1'b0, "err_no_valid",
              128'(sel ? d2_rk_valid : rk_valid), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor / consumer: drives ready, checks every handshake against the queue
    bit           prev_stall = 0;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    bit           expect_done = 0;
    int           stall_cnt = 0;
    exp_t         got;

    initial begin
        rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall  = 0;
                expect_done = 0;
                stall_cnt   = 0;
                rdy         = 1'b1;
            end else begin
                if (rk_valid && stall_idx >= 0 && int'(rk_idx) == stall_idx && !stall_used) begin
                    stall_cnt  = 10;
                    stall_used = 1;
                end
                if (stall_cnt > 0) begin
                    rdy = 1'b0;
                    stall_cnt--;
                end else begin
                    rdy = 1'b1;
                end

                if (expect_done) begin
                    check(done == 1'b1, "done_pulse", 128'(done), 128'd1);
                    check(busy == 1'b0, "busy_with_done", 128'(busy), 128'd0);
                    expect_done = 0;
                end else begin
                    check(done == 1'b0, "no_spurious_done", 128'(done), 128'd0);
                end

                if (prev_stall) begin
                    check(rk_valid == 1'b1, "stall_valid_held", 128'(rk_valid), 128'd1);
                    check(rk == prev_rk, "stall_rk_stable", rk, prev_rk);
                    check(rk_idx == prev_idx, "stall_idx_stable", 128'(rk_idx), 128'(prev_idx));
                end
                prev_stall = rk_valid && !rdy;
                prev_rk    = rk;
                prev_idx   = rk_idx;

                if (rk_valid && rdy) begin
                    check(sb_q.size() != 0, "unexpected_rk", 128'(rk_idx), 128'd0);
                    if (sb_q.size() != 0) begin
                        got = sb_q.pop_front();
                        check(rk_idx == got.idx, "rk_idx", 128'(rk_idx), 128'(got.idx));
                        check(rk_last == got.last, "rk_last", 128'(rk_last), 128'(got.last));
                        if (got.chk_rk)
                            check(rk == got.rk, $sformatf("rk%0d", got.idx), rk, got.rk);
                        if (got.edge_n >= 0)
                            check(cyc - e0_cyc == got.edge_n, $sformatf("latency_rk%0d", got.idx),
                                  128'(cyc - e0_cyc), 128'(got.edge_n));
                        if (got.last) expect_done = 1;
                    end
                end
            end
        end
    end

    // Stimulus
    bit found;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        d2_start = 1'b0;
        d2_rdy   = 1'b1;
        key_len  = 2'd0;
        key      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check(rk == '0, "reset_rk", rk, 128'd0);
        check(rk_idx == 4'd0, "reset_idx", 128'(rk_idx), 128'd0);
        check({rk_last, rk_valid, busy, done, err} == 5'd0, "reset_flags",
              128'({rk_last, rk_valid, busy, done, err}), 128'd0);
        @(posedge clk);
        #1;

        // AES-128, unused key LSBs set to ones, ready always high
        push_sched(0, 1'b1);
        start_run(2'd0, {K128, {128{1'b1}}});
        wait_done(200);

        // AES-192 started in the done cycle of the previous run
        push_sched(1, 1'b1);
        start_run(2'd1, {K192, 64'ha5a5a5a5a5a5a5a5});
        wait_done(200);

        // AES-256 with a 10-cycle consumer stall on rk2
        stall_idx  = 2;
        stall_used = 0;
        push_sched(2, 1'b0);
        start_run(2'd2, K256);
        wait_done(300);
        stall_idx = -1;

        // Illegal starts
        @(posedge clk);
        #1;
        err_test(1'b0);
        err_test(1'b1);

        // Abort an AES-256 run at rk5
        push_sched(2, 1'b0);
        start_run(2'd2, K256);
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk);
            #2;
            if (rk_valid && rk_idx == 4'd5) found = 1;
        end
        check(found, "rk5_reached", 128'(found), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check(rk_valid == 1'b0, "abort_valid_low", 128'(rk_valid), 128'd0);
        check(busy == 1'b0, "abort_busy_low", 128'(busy), 128'd0);
        repeat (8) @(posedge clk);
        #1;

        // AES-128 after abort, with a foreign start pulsed mid-run
        push_sched(0, 1'b1);
        start_run(2'd0, {K128, 128'h0});
        repeat (9) @(posedge clk);
        #1;
        start   = 1'b1;
        key_len = 2'd2;
        key     = {256{1'b1}};
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);

        repeat (5) @(posedge clk);
        #1;
        check(sb_q.size() == 0, "sb_drained", 128'(sb_q.size()), 128'd0);
        check({d2_rk_valid, d2_busy, d2_done, d2_rk_last} == 4'd0 && d2_rk == '0 && d2_rk_idx == 4'd0,
              "n192_idle", d2_rk, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_key_expansion_seq.md
# aes_key_expansion_seq

Iterative, runtime-configurable AES key schedule for AES-128, AES-192 and AES-256. It produces one 32-bit schedule word per cycle using a single shared SubWord unit. Words are packed into 128-bit round keys and streamed out with a valid/ready handshake. It replaces the fully combinational 256-bit expander where LUT budget matters more than latency, and it feeds the iterative cipher core, which consumes round keys in order.

## Interface
- `ENABLE_192`, default 1: when 0, AES-192 is rejected as illegal.
- `ENABLE_256`, default 1: when 0, AES-256 is rejected as illegal.
- `clk_i` input, 1 bit: clock; every register updates on the rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `start_i` input, 1 bit: request a schedule; sampled only in IDLE.
- `key_len_i` input, 2 bits: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal; sampled with `start_i`.
- `key_i` input, 256 bits: master key, left-justified. w0 = `key_i[255:224]`; unused LSBs are ignored. Latched on start.
- `rk_o` output, 128 bits: round key {w[4j], w[4j+1], w[4j+2], w[4j+3]}.
- `rk_idx_o` output, 4 bits: round index j, 0..Nr.
- `rk_last_o` output, 1 bit: high with round key Nr.
- `rk_valid_o` output, 1 bit: round key present.
- `rk_ready_i` input, 1 bit: consumer accepts.
- `busy_o` output, 1 bit: high in GEN.
- `done_o` output, 1 bit: one-cycle pulse after the final handshake.
- `err_o` output, 1 bit: one-cycle pulse on an illegal start.

## Operation
- Schedule sizes: Nk = 4/6/8 and Nr = 10/12/14, giving 44/52/60 words total.
- States: IDLE and GEN.
  - IDLE→GEN when `start_i` is high and the mode is legal. On that edge, latch the key and mode, set word counter i = 0, and set rcon = 8'h01.
  - An illegal start (mode 3, or a disabled mode) stays in IDLE and pulses `err_o`.
  - GEN→IDLE on the handshake of round key Nr; `done_o` pulses in the following cycle.
- Word generation, one word per enabled GEN cycle:
  - For i < Nk: w[i] is key word i.
  - Otherwise: temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon ← xtime(rcon) (polynomial 0x11B).
    - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
    - Then w[i] = w[i-Nk] ^ temp.
- History window: an 8×32 shift register, newest word at position 0. w[i-Nk] is read from window position Nk-1.
- Packing: each word is written into lane (i mod 4) of the pack register. When lane 3 is written, the pack register moves into `rk_o`, `rk_valid_o` is set, and `rk_idx_o` = i>>2.
- Stall: generation is enabled unless (i mod 4 == 3 and `rk_valid_o` and !`rk_ready_i`).
- Handshake:
  - `rk_valid_o` holds, and `rk_o`, `rk_idx_o` and `rk_last_o` stay stable, until `rk_ready_i` is high.
  - `rk_valid_o` drops after the handshake unless a new key loads on that same edge. A simultaneous accept and load keeps valid high.
- `start_i` while busy is ignored and has no effect on the schedule in progress.
- `rst_i` mid-operation aborts: return to IDLE, discard partial words, no `done_o`.

## Timing
- Reset values: all outputs are 0 (`rk_o`, `rk_idx_o`, `rk_last_o`, `rk_valid_o`, `busy_o`, `done_o`, `err_o`). State is IDLE, counters are 0, rcon = 8'h01.
- Let E0 be the start edge. Word i is written at edge E(i+1), and `rk_valid_o` first rises after E4.
- Without backpressure, round key j is valid after E(4j+4), so the last key appears after E44/E52/E60 for AES-128/192/256.
- Sustained throughput is one round key per 4 cycles; the consumer may delay up to 3 cycles per key without stalling generation.
- `err_o` is high in the cycle after E0. `done_o` is high in the cycle after the final handshake, and `busy_o` is low in that cycle.
- The next start is accepted in the same cycle `done_o` is high.

## Structure
- Package `aes_pkg` holds:
  - the S-box function;
  - `xtime`;
  - the key-length encodings (`KEYLEN_128`, `KEYLEN_192`, `KEYLEN_256`);
  - Nk and Nr lookup functions;
  - the state enum.
- Sub-module `aes_sub_word` contains four S-box instances and is purely combinational. One instance is shared for both the RotWord path and the i mod 8 == 4 path.
- Counter widths: word counter 6 bits, round index 4 bits.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready_i` = 1 → rk0 = key; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last_o`; `done_o` one cycle later.
- AES-192, key 000102…1617 → rk12 = a4970a331a78dc09c418c271e3a41d5d; 13 handshakes total, and rk3 lands after E16.
- AES-256, key 000102…1e1f, with `rk_ready_i` low for 10 cycles on rk2 → `rk_o` and `rk_idx_o` stable throughout the stall; rk14 = 24fc79ccbf0979e9371ac23c6d68de36; no key skipped or duplicated.
- `key_len_i` = 3, and separately `ENABLE_192` = 0 with mode 1 → `err_o` is a one-cycle pulse, `busy_o` stays 0, no `rk_valid_o`.
- Assert `rst_i` at rk5 of an AES-256 run, then restart with AES-128 → the AES-128 vector is correct, and no stale rk or `done_o` appears from the aborted run.
- Pulse `start_i` with a different key mid-run → it is ignored and the original schedule completes correctly.
